// File: rtl/measure_xgmii.sv
// measure_xgmii: 10G XGMII traffic generator and receive-rate meter.
//
// The generator on xgmii_0_tx emits back-to-back broadcast UDP frames (or ARP
// requests) separated by a programmable inter-frame gap. Each frame carries a
// 32-bit sequence number and a valid IEEE 802.3 FCS. The meter on xgmii_1_rx
// counts frames and bytes per measurement window of CLK_PER_SEC cycles.
//
// Ports:
//   sys_clk, sys_rst            clock, async active-high reset
//   xgmii_0_txd/txc             generator output (64-bit data, 8 control bits)
//   xgmii_0_rxd/rxc             unused input
//   xgmii_1_txd/txc             constant idle output
//   xgmii_1_rxd/rxc             measured input
//   tx0_enable                  generator run
//   tx0_ipv6                    reserved, ignored
//   tx0_fullroute               sweep destination IP with the sequence number
//   tx0_req_arp                 send ARP requests instead of UDP frames
//   tx0_frame_len               frame bytes, destination MAC through FCS
//   tx0_inter_frame_gap         gap bytes between frames
//   tx0_ipv4_srcip/gwip/dstip   IPv4 addresses
//   tx0_src_mac                 source MAC
//   tx0_ipv6_srcip/dstip        reserved, ignored
//   tx0_pps                     frames received in the last window
//   tx0_throughput              bytes received in the last window
//   tx0_ipv4_ip                 destination IP of the last started UDP frame
module measure_xgmii #(
  parameter int CLK_PER_SEC = 156250000,
  parameter int FRAME_MAX   = 1518
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  output logic [63:0]  xgmii_0_txd,
  output logic [7:0]   xgmii_0_txc,
  input  logic [63:0]  xgmii_0_rxd,
  input  logic [7:0]   xgmii_0_rxc,
  output logic [63:0]  xgmii_1_txd,
  output logic [7:0]   xgmii_1_txc,
  input  logic [63:0]  xgmii_1_rxd,
  input  logic [7:0]   xgmii_1_rxc,
  input  logic         tx0_enable,
  input  logic         tx0_ipv6,
  input  logic         tx0_fullroute,
  input  logic         tx0_req_arp,
  input  logic [15:0]  tx0_frame_len,
  input  logic [31:0]  tx0_inter_frame_gap,
  input  logic [31:0]  tx0_ipv4_srcip,
  input  logic [31:0]  tx0_ipv4_gwip,
  input  logic [31:0]  tx0_ipv4_dstip,
  input  logic [47:0]  tx0_src_mac,
  input  logic [127:0] tx0_ipv6_srcip,
  input  logic [127:0] tx0_ipv6_dstip,
  output logic [31:0]  tx0_pps,
  output logic [31:0]  tx0_throughput,
  output logic [31:0]  tx0_ipv4_ip
);

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;
  localparam logic [7:0]  START_C = 8'h01;
  localparam logic [15:0] LEN_MAX = 16'(FRAME_MAX);
  localparam logic [31:0] WIN_LAST = 32'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_IFG} state_t;

  // Reflected CRC-32 (poly 0xEDB88320) over the lanes selected by mask, lane 0 first.
  function automatic logic [31:0] crc32_lanes(input logic [31:0] crc_in,
                                              input logic [63:0] data,
                                              input logic [7:0]  mask);
    logic [31:0] c;
    c = crc_in;
    for (int j = 0; j < 8; j++) begin
      if (mask[j]) begin
        for (int b = 0; b < 8; b++) begin
          if (c[0] ^ data[8*j+b]) c = (c >> 1) ^ 32'hEDB88320;
          else                    c = c >> 1;
        end
      end
    end
    return c;
  endfunction

  // Ones'-complement IPv4 header checksum; the constant words are 0x4500
  // (version/IHL/TOS) and 0x4011 (TTL 64, protocol UDP), flags/frag are 0.
  function automatic logic [15:0] ip_csum(input logic [15:0] tot_len,
                                          input logic [15:0] id,
                                          input logic [31:0] src,
                                          input logic [31:0] dst);
    logic [19:0] s;
    s = 20'h04500 + {4'h0, tot_len} + {4'h0, id} + 20'h04011
      + {4'h0, src[31:16]} + {4'h0, src[15:0]}
      + {4'h0, dst[31:16]} + {4'h0, dst[15:0]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    return ~s[15:0];
  endfunction

  state_t       state_r, state_s;
  logic [15:0]  w_r;
  logic [29:0]  ifg_cnt_r, ifg_words_r;
  logic [15:0]  len_r;
  logic [383:0] hdr_r;
  logic [31:0]  crc_r, seq_r, ip_r;
  logic [63:0]  txd_r;
  logic [7:0]   txc_r;

  logic [15:0]  len_sel_s, tot_len_s, udp_len_s, csum_s;
  logic [31:0]  dstip_s, ifg_eff_s, fcs_s, crc_next_s;
  logic [32:0]  ifg_sum_s;
  logic [383:0] hdr_s;
  logic [19:0]  len20_s, data_end_s;
  logic [63:0]  lane_data_s, word_d_s;
  logic [7:0]   data_mask_s, word_c_s;

  // Ignored inputs are gathered here so they are visibly intentional.
  logic unused_s;
  assign unused_s = ^{xgmii_0_rxd, xgmii_0_rxc, tx0_ipv6, tx0_ipv6_srcip, tx0_ipv6_dstip};

  // ---------------- frame configuration (used at the start word) ----------
  // Clamp the requested length; ARP requests are always minimum size.
  always_comb begin
    len_sel_s = tx0_frame_len;
    if (tx0_req_arp)                    len_sel_s = 16'd64;
    else if (tx0_frame_len < 16'd64)    len_sel_s = 16'd64;
    else if (tx0_frame_len > LEN_MAX)   len_sel_s = LEN_MAX;
    else                                len_sel_s = tx0_frame_len;
  end

  assign dstip_s   = tx0_fullroute ? (tx0_ipv4_dstip + seq_r) : tx0_ipv4_dstip;
  assign tot_len_s = len_sel_s - 16'd18;
  assign udp_len_s = len_sel_s - 16'd38;
  assign csum_s    = ip_csum(tot_len_s, seq_r[15:0], tx0_ipv4_srcip, dstip_s);
  assign ifg_eff_s = (tx0_inter_frame_gap == 32'h0) ? 32'h1 : tx0_inter_frame_gap;
  assign ifg_sum_s = {1'b0, ifg_eff_s} + 33'd7;

  // First 48 frame bytes, byte 0 in the top bits; everything beyond is zero.
  assign hdr_s = tx0_req_arp ?
    {48'hFFFFFFFFFFFF, tx0_src_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
     16'h0001, tx0_src_mac, tx0_ipv4_srcip, 48'h0, tx0_ipv4_gwip, 48'h0} :
    {48'hFFFFFFFFFFFF, tx0_src_mac, 16'h0800, 8'h45, 8'h00, tot_len_s,
     seq_r[15:0], 16'h0000, 8'h40, 8'h11, csum_s, tx0_ipv4_srcip, dstip_s,
     16'd3000, 16'd3000, udp_len_s, 16'h0000, seq_r, 16'h0000};

  // ---------------- generator ----------------
  assign len20_s    = {4'h0, len_r};
  assign data_end_s = len20_s - 20'd4;

  // Header/payload bytes for the current data word and which lanes feed the CRC.
  always_comb begin
    lane_data_s = 64'h0;
    data_mask_s = 8'h00;
    for (int j = 0; j < 8; j++) begin
      logic [19:0] pos;
      pos = {1'b0, w_r, 3'b000} + 20'(j);
      if (state_r == ST_DATA && pos < data_end_s) begin
        data_mask_s[j] = 1'b1;
        if (pos < 20'd48) lane_data_s[8*j +: 8] = 8'(hdr_r >> (9'd376 - {pos[5:0], 3'b000}));
        else              lane_data_s[8*j +: 8] = 8'h00;
      end else begin
        data_mask_s[j] = 1'b0;
      end
    end
  end

  // Once data ends the CRC stops changing, so the FCS is valid in every
  // lane that carries it, including when it straddles two words.
  assign crc_next_s = crc32_lanes(crc_r, lane_data_s, data_mask_s);
  assign fcs_s      = ~crc_next_s;

  // Assemble the XGMII word for the current state; byte position len_r is terminate.
  always_comb begin
    word_d_s = IDLE_D;
    word_c_s = IDLE_C;
    case (state_r)
      ST_START: begin
        word_d_s = START_D;
        word_c_s = START_C;
      end
      ST_DATA: begin
        for (int j = 0; j < 8; j++) begin
          logic [19:0] pos;
          logic [19:0] k;
          pos = {1'b0, w_r, 3'b000} + 20'(j);
          k   = pos - data_end_s;
          if (pos < data_end_s) begin
            word_d_s[8*j +: 8] = lane_data_s[8*j +: 8];
            word_c_s[j]        = 1'b0;
          end else if (pos < len20_s) begin
            word_d_s[8*j +: 8] = 8'(fcs_s >> {k[1:0], 3'b000});
            word_c_s[j]        = 1'b0;
          end else if (pos == len20_s) begin
            word_d_s[8*j +: 8] = 8'hFD;
            word_c_s[j]        = 1'b1;
          end else begin
            word_d_s[8*j +: 8] = 8'h07;
            word_c_s[j]        = 1'b1;
          end
        end
      end
      default: begin
        word_d_s = IDLE_D;
        word_c_s = IDLE_C;
      end
    endcase
  end

  // Next-state logic: the word holding byte position L is the last data word.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx0_enable) state_s = ST_START;
        else            state_s = ST_IDLE;
      end
      ST_START: state_s = ST_DATA;
      ST_DATA: begin
        if (w_r == {3'b000, len_r[15:3]}) state_s = ST_IFG;
        else                              state_s = ST_DATA;
      end
      ST_IFG: begin
        if (ifg_cnt_r == ifg_words_r - 30'd1) state_s = tx0_enable ? ST_START : ST_IDLE;
        else                                  state_s = ST_IFG;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, word/gap counters and per-frame configuration capture.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      w_r         <= 16'h0;
      ifg_cnt_r   <= 30'h0;
      ifg_words_r <= 30'h1;
      len_r       <= 16'd64;
      hdr_r       <= 384'h0;
      crc_r       <= 32'hFFFFFFFF;
      seq_r       <= 32'h0;
      ip_r        <= 32'h0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_START: begin
          w_r         <= 16'h0;
          ifg_words_r <= ifg_sum_s[32:3];
          len_r       <= len_sel_s;
          hdr_r       <= hdr_s;
          crc_r       <= 32'hFFFFFFFF;
          seq_r       <= seq_r + 32'h1;
          if (!tx0_req_arp) ip_r <= dstip_s;
        end
        ST_DATA: begin
          w_r       <= w_r + 16'h1;
          crc_r     <= crc_next_s;
          ifg_cnt_r <= 30'h0;
        end
        ST_IFG:  ifg_cnt_r <= ifg_cnt_r + 30'h1;
        default: ifg_cnt_r <= 30'h0;
      endcase
    end
  end

  // Registered TX word; reset forces idle immediately, truncating any frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      txd_r <= IDLE_D;
      txc_r <= IDLE_C;
    end else begin
      txd_r <= word_d_s;
      txc_r <= word_c_s;
    end
  end

  assign xgmii_0_txd = txd_r;
  assign xgmii_0_txc = txc_r;
  assign xgmii_1_txd = IDLE_D;
  assign xgmii_1_txc = IDLE_C;
  assign tx0_ipv4_ip = ip_r;

  // ---------------- receiver / rate meter ----------------
  logic        in_frame_r;
  logic [31:0] acc_r, win_r, frame_cnt_r, byte_cnt_r, pps_r, thr_r;
  logic        rx_start_s, term_hit_s, rx_done_s;
  logic [3:0]  term_lane_s;
  logic [31:0] rx_bytes_s, byte_add_s, frame_add_s;

  assign rx_start_s = xgmii_1_rxc[0] && (xgmii_1_rxd[7:0] == 8'hFB);

  // Locate the lowest lane carrying a terminate control character.
  always_comb begin
    term_hit_s  = 1'b0;
    term_lane_s = 4'h0;
    for (int j = 0; j < 8; j++) begin
      if (!term_hit_s && xgmii_1_rxc[j] && (xgmii_1_rxd[8*j +: 8] == 8'hFD)) begin
        term_hit_s  = 1'b1;
        term_lane_s = 4'(j);
      end else begin
        term_hit_s = term_hit_s;
      end
    end
  end

  assign rx_done_s   = in_frame_r && !rx_start_s && term_hit_s;
  assign rx_bytes_s  = acc_r + {28'h0, term_lane_s};
  assign byte_add_s  = rx_done_s ? rx_bytes_s : 32'h0;
  assign frame_add_s = {31'h0, rx_done_s};

  // Frame tracking: a start word always (re)opens a frame with zero bytes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_frame_r <= 1'b0;
      acc_r      <= 32'h0;
    end else if (rx_start_s) begin
      in_frame_r <= 1'b1;
      acc_r      <= 32'h0;
    end else if (in_frame_r && term_hit_s) begin
      in_frame_r <= 1'b0;
      acc_r      <= 32'h0;
    end else if (in_frame_r) begin
      acc_r <= acc_r + 32'd8;
    end
  end

  // Window counter and per-window counts; the wrap cycle includes its own frame end.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      win_r       <= 32'h0;
      frame_cnt_r <= 32'h0;
      byte_cnt_r  <= 32'h0;
      pps_r       <= 32'h0;
      thr_r       <= 32'h0;
    end else if (win_r == WIN_LAST) begin
      win_r       <= 32'h0;
      pps_r       <= frame_cnt_r + frame_add_s;
      thr_r       <= byte_cnt_r + byte_add_s;
      frame_cnt_r <= 32'h0;
      byte_cnt_r  <= 32'h0;
    end else begin
      win_r       <= win_r + 32'h1;
      frame_cnt_r <= frame_cnt_r + frame_add_s;
      byte_cnt_r  <= byte_cnt_r + byte_add_s;
    end
  end

  assign tx0_pps        = pps_r;
  assign tx0_throughput = thr_r;

endmodule

// File: tb/tb_measure_xgmii.sv
module tb_measure_xgmii;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic [63:0]  x0_txd, x1_txd;
  logic [7:0]   x0_txc, x1_txc;
  logic [63:0]  x0_rxd = 64'h0707070707070707;
  logic [7:0]   x0_rxc = 8'hFF;
  logic         enable = 1'b0, ipv6 = 1'b0, fullroute = 1'b0, req_arp = 1'b0;
  logic [15:0]  frame_len = 16'd68;
  logic [31:0]  ifg = 32'd12;
  logic [31:0]  srcip = 32'hC0A8010A, gwip = 32'hC0A80101, dstip = 32'hC0A80266;
  logic [47:0]  src_mac = 48'h001122334466;
  logic [127:0] v6_src = 128'h0, v6_dst = 128'h0;
  logic [31:0]  pps, thr, ip;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] fb [0:2047];
  int fn, nwords, term_lane, n_idle, start_cyc;
  logic [63:0] first_d;
  logic [7:0]  first_c, term_c;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  measure_xgmii #(.CLK_PER_SEC(1000), .FRAME_MAX(1518)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .xgmii_0_txd(x0_txd), .xgmii_0_txc(x0_txc),
    .xgmii_0_rxd(x0_rxd), .xgmii_0_rxc(x0_rxc),
    .xgmii_1_txd(x1_txd), .xgmii_1_txc(x1_txc),
    .xgmii_1_rxd(x0_txd), .xgmii_1_rxc(x0_txc),
    .tx0_enable(enable), .tx0_ipv6(ipv6), .tx0_fullroute(fullroute),
    .tx0_req_arp(req_arp), .tx0_frame_len(frame_len),
    .tx0_inter_frame_gap(ifg), .tx0_ipv4_srcip(srcip), .tx0_ipv4_gwip(gwip),
    .tx0_ipv4_dstip(dstip), .tx0_src_mac(src_mac),
    .tx0_ipv6_srcip(v6_src), .tx0_ipv6_dstip(v6_dst),
    .tx0_pps(pps), .tx0_throughput(thr), .tx0_ipv4_ip(ip)
  );

  // Reference CRC-32: MSB-first shift register, bits fed LSB-first, output reflected.
  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c, r;
    logic f;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        f = c[31] ^ fb[i][b];
        c = c << 1;
        if (f) c = c ^ 32'h04C11DB7;
      end
    c = ~c;
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return r;
  endfunction

  function automatic logic [15:0] be16(input int i);
    return {fb[i], fb[i+1]};
  endfunction

  function automatic logic [31:0] be32(input int i);
    return {fb[i], fb[i+1], fb[i+2], fb[i+3]};
  endfunction

  function automatic logic [31:0] got_fcs();
    return {fb[fn-1], fb[fn-2], fb[fn-3], fb[fn-4]};
  endfunction

  task automatic do_reset();
    enable  = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Wait for a start word, then collect data bytes until the terminate lane.
  task automatic capture_frame(output bit ok);
    int guard;
    bit done;
    ok = 1'b0; done = 1'b0; guard = 0; n_idle = 0;
    @(negedge sys_clk);
    while (!(x0_txd == START_D && x0_txc == 8'h01) && guard < 4000) begin
      if (x0_txd == IDLE_D && x0_txc == 8'hFF) n_idle++;
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 4000) begin
      total++; bad++;
      $display("FAIL start_timeout got=none required=start word");
      return;
    end
    start_cyc = cyc; fn = 0; nwords = 1;
    while (!done && guard < 4000) begin
      @(negedge sys_clk);
      guard++; nwords++;
      if (nwords == 2) begin first_d = x0_txd; first_c = x0_txc; end
      for (int j = 0; j < 8; j++) begin
        if (!done) begin
          if (!x0_txc[j]) begin
            if (fn < 2048) fb[fn] = x0_txd[8*j +: 8];
            fn++;
          end else if (x0_txd[8*j +: 8] == 8'hFD) begin
            done = 1'b1; term_lane = j; term_c = x0_txc;
          end
        end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL term_timeout got=none required=terminate");
      return;
    end
    ok = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++; if (x0_txd !== IDLE_D || x0_txc !== 8'hFF) begin bad++; $display("FAIL rst_tx0 got=%h/%h required=%h/ff", x0_txd, x0_txc, IDLE_D); end
    total++; if (x1_txd !== IDLE_D || x1_txc !== 8'hFF) begin bad++; $display("FAIL rst_tx1 got=%h/%h required=%h/ff", x1_txd, x1_txc, IDLE_D); end
    total++; if (pps !== 32'h0 || thr !== 32'h0 || ip !== 32'h0) begin bad++; $display("FAIL rst_counts got=%h/%h/%h required=0/0/0", pps, thr, ip); end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++; if (x0_txd === START_D) begin bad++; $display("FAIL early_start got=%h required=not start after first edge", x0_txd); end
    enable = 1'b0;
  endtask

  task automatic test_udp_basic();
    bit ok;
    int c0;
    do_reset();
    fullroute = 1'b0; req_arp = 1'b0; frame_len = 16'd68; ifg = 32'd12;
    enable = 1'b1;
    capture_frame(ok);
    c0 = start_cyc;
    total++; if (first_d !== 64'h1100FFFFFFFFFFFF || first_c !== 8'h00) begin bad++; $display("FAIL first_word got=%h/%h required=1100ffffffffffff/00", first_d, first_c); end
    total++; if (nwords != 10 || term_lane != 4 || term_c !== 8'hF0) begin bad++; $display("FAIL term_pos got=%0d/%0d/%h required=10/4/f0", nwords, term_lane, term_c); end
    total++; if (fn != 68) begin bad++; $display("FAIL udp_len got=%0d required=68", fn); end
    total++; if (be16(12) !== 16'h0800 || be16(16) !== 16'h0032 || be16(18) !== 16'h0000) begin bad++; $display("FAIL ip_hdr got=%h/%h/%h required=0800/0032/0000", be16(12), be16(16), be16(18)); end
    total++; if (be16(24) !== 16'hF5FA) begin bad++; $display("FAIL ip_csum got=%h required=f5fa", be16(24)); end
    total++; if (be32(26) !== 32'hC0A8010A || be32(30) !== 32'hC0A80266) begin bad++; $display("FAIL ip_addr got=%h/%h required=c0a8010a/c0a80266", be32(26), be32(30)); end
    total++; if (be32(34) !== 32'h0BB80BB8 || be16(38) !== 16'h001E || be16(40) !== 16'h0000) begin bad++; $display("FAIL udp_hdr got=%h/%h/%h required=0bb80bb8/001e/0000", be32(34), be16(38), be16(40)); end
    total++; if (be32(42) !== 32'h0 || fb[50] !== 8'h00) begin bad++; $display("FAIL payload0 got=%h/%h required=0/0", be32(42), fb[50]); end
    total++; if (got_fcs() !== ref_fcs(64)) begin bad++; $display("FAIL fcs0 got=%h required=%h", got_fcs(), ref_fcs(64)); end
    total++; if (ip !== 32'hC0A80266) begin bad++; $display("FAIL ipv4_ip got=%h required=c0a80266", ip); end
    capture_frame(ok);
    total++; if (n_idle != 2 || start_cyc - c0 != 12) begin bad++; $display("FAIL ifg_period got=%0d/%0d required=2/12", n_idle, start_cyc - c0); end
    total++; if (be16(18) !== 16'h0001 || be32(42) !== 32'h1 || be16(24) !== 16'hF5F9) begin bad++; $display("FAIL frame1 got=%h/%h/%h required=0001/1/f5f9", be16(18), be32(42), be16(24)); end
    total++; if (got_fcs() !== ref_fcs(64)) begin bad++; $display("FAIL fcs1 got=%h required=%h", got_fcs(), ref_fcs(64)); end
    capture_frame(ok);
    total++; if (be16(18) !== 16'h0002) begin bad++; $display("FAIL frame2_id got=%h required=0002", be16(18)); end
    enable = 1'b0;
  endtask

  task automatic test_fullroute();
    bit ok;
    logic [31:0] exp;
    do_reset();
    fullroute = 1'b1; req_arp = 1'b0; frame_len = 16'd68; ifg = 32'd12;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      capture_frame(ok);
      exp = 32'hC0A80266 + k;
      total++; if (be32(30) !== exp || ip !== exp) begin bad++; $display("FAIL fullroute_%0d got=%h/%h required=%h", k, be32(30), ip, exp); end
    end
    enable = 1'b0; fullroute = 1'b0;
  endtask

  task automatic test_arp();
    bit ok;
    do_reset();
    req_arp = 1'b1; frame_len = 16'd200; gwip = 32'hC0A80101;
    enable = 1'b1;
    capture_frame(ok);
    total++; if (fn != 64 || term_lane != 0 || term_c !== 8'hFF) begin bad++; $display("FAIL arp_len got=%0d/%0d/%h required=64/0/ff", fn, term_lane, term_c); end
    total++; if (be16(12) !== 16'h0806 || be32(14) !== 32'h00010800 || be32(18) !== 32'h06040001) begin bad++; $display("FAIL arp_hdr got=%h/%h/%h required=0806/00010800/06040001", be16(12), be32(14), be32(18)); end
    total++; if (be16(22) !== 16'h0011 || be32(28) !== 32'hC0A8010A || be32(32) !== 32'h0 || be32(38) !== 32'hC0A80101) begin bad++; $display("FAIL arp_fields got=%h/%h/%h/%h required=0011/c0a8010a/0/c0a80101", be16(22), be32(28), be32(32), be32(38)); end
    total++; if (got_fcs() !== ref_fcs(60) || ip !== 32'h0) begin bad++; $display("FAIL arp_fcs_ip got=%h/%h required=%h/0", got_fcs(), ip, ref_fcs(60)); end
    enable = 1'b0; req_arp = 1'b0;
  endtask

  task automatic test_clamp();
    bit ok;
    do_reset();
    frame_len = 16'd10; ifg = 32'd0;
    enable = 1'b1;
    capture_frame(ok);
    total++; if (fn != 64 || nwords != 10 || term_lane != 0 || term_c !== 8'hFF) begin bad++; $display("FAIL clamp_min got=%0d/%0d/%0d/%h required=64/10/0/ff", fn, nwords, term_lane, term_c); end
    frame_len = 16'd2000;
    capture_frame(ok);
    total++; if (n_idle != 1) begin bad++; $display("FAIL ifg_zero got=%0d required=1", n_idle); end
    capture_frame(ok);
    total++; if (fn != 1518 || nwords != 191 || term_lane != 6 || term_c !== 8'hC0) begin bad++; $display("FAIL clamp_max got=%0d/%0d/%0d/%h required=1518/191/6/c0", fn, nwords, term_lane, term_c); end
    total++; if (be16(16) !== 16'd1500 || got_fcs() !== ref_fcs(1514)) begin bad++; $display("FAIL long_frame got=%h/%h required=%h/%h", be16(16), got_fcs(), 16'd1500, ref_fcs(1514)); end
    enable = 1'b0; frame_len = 16'd68; ifg = 32'd12;
  endtask

  task automatic test_window();
    do_reset();
    frame_len = 16'd68; ifg = 32'd12;
    enable = 1'b1;
    repeat (500) @(negedge sys_clk);
    total++; if (pps !== 32'h0) begin bad++; $display("FAIL pps_before_wrap got=%0d required=0", pps); end
    repeat (1600) @(negedge sys_clk);
    total++; if (pps != 83 && pps != 84) begin bad++; $display("FAIL pps got=%0d required=83 or 84", pps); end
    total++; if (thr !== 68 * pps) begin bad++; $display("FAIL throughput got=%0d required=%0d", thr, 68 * pps); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int guard, cnt, idle_cnt;
    bit done;
    do_reset();
    enable = 1'b1;
    guard = 0; cnt = 0; done = 1'b0;
    while (!(x0_txd == START_D && x0_txc == 8'h01) && guard < 200) begin @(negedge sys_clk); guard++; end
    for (int w = 0; w < 40 && !done; w++) begin
      @(negedge sys_clk);
      if (w == 2) enable = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (!done) begin
          if (!x0_txc[j]) cnt++;
          else if (x0_txd[8*j +: 8] == 8'hFD) done = 1'b1;
        end
      end
    end
    total++; if (!done || cnt != 68) begin bad++; $display("FAIL drop_complete got=%0d/%0d required=1/68", done, cnt); end
    idle_cnt = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (x0_txd === IDLE_D && x0_txc === 8'hFF) idle_cnt++;
    end
    total++; if (idle_cnt != 30) begin bad++; $display("FAIL drop_idle got=%0d required=30", idle_cnt); end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    enable = 1'b1;
    guard = 0;
    while (!(x0_txd == START_D && x0_txc == 8'h01) && guard < 200) begin @(negedge sys_clk); guard++; end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    total++; if (x0_txd !== IDLE_D || x0_txc !== 8'hFF || ip !== 32'h0) begin bad++; $display("FAIL reset_mid got=%h/%h/%h required=%h/ff/0", x0_txd, x0_txc, ip, IDLE_D); end
    @(negedge sys_clk);
    total++; if (x0_txd !== IDLE_D || x0_txc !== 8'hFF) begin bad++; $display("FAIL reset_hold got=%h/%h required=%h/ff", x0_txd, x0_txc, IDLE_D); end
    enable = 1'b0;
    sys_rst = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_udp_basic();
    test_fullroute();
    test_arp();
    test_clamp();
    test_window();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
